// File: rtl/sig_period_meter_pkg.sv
// Shared definitions for sig_period_meter: FSM encoding, synchronizer depth
// and averaging geometry.
package sig_period_meter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_MEASURE = 2'd1;
    localparam state_t ST_STALLED = 2'd2;

    localparam int SYNC_STAGES = 2;
    localparam int AVG_DEPTH   = 4;
    localparam int AVG_SHIFT   = 2;

endpackage

// File: rtl/sig_period_meter_sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge detector;
// rise_pulse is a one-cycle pulse three cycles after the async input rises.
module sync_edge_det
    import sig_period_meter_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic                   prev_d, prev_q;
    logic                   rise_d, rise_q;

    // next-state for synchronizer chain and edge register
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // state registers
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise_pulse = rise_q;

endmodule

// File: rtl/sig_period_meter.sv
// Period meter for a slow asynchronous square wave, with stall detection.
// Define SIG_PERIOD_METER_AVG_EN to report the mean of the last four periods.
module sig_period_meter
    import sig_period_meter_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_COUNT = 65534
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COUNT);

    logic             rise_s;
    logic             sample_s;
    logic             enter_s;
    logic [CNT_W-1:0] raw_inc_s;
    logic [CNT_W-1:0] report_period_s;
    logic             report_valid_s;

    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] period_d, period_q;
    logic             valid_d, valid_q;
    logic             stalled_d, stalled_q;

    sync_edge_det u_sync_edge_det (
        .clk_in     (clk_in),
        .reset      (reset),
        .async_in   (sig_in),
        .rise_pulse (rise_s)
    );

    assign raw_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign sample_s  = rise_s & (state_q == ST_MEASURE);
    assign enter_s   = rise_s & (state_q != ST_MEASURE);

`ifdef SIG_PERIOD_METER_AVG_EN
    logic [CNT_W-1:0] hist_d [AVG_DEPTH];
    logic [CNT_W-1:0] hist_q [AVG_DEPTH];
    logic [CNT_W+1:0] sum_d, sum_q;
    logic [2:0]       fill_d, fill_q;

    // running sum over the history window; oldest entry drops out as the new one enters
    always_comb begin
        hist_d          = hist_q;
        sum_d           = sum_q;
        fill_d          = fill_q;
        report_valid_s  = 1'b0;
        report_period_s = '0;
        if (enter_s) begin
            for (int i = 0; i < AVG_DEPTH; i++) begin
                hist_d[i] = '0;
            end
            sum_d  = '0;
            fill_d = 3'd0;
        end else if (sample_s) begin
            sum_d = sum_q - {2'b00, hist_q[AVG_DEPTH-1]} + {2'b00, raw_inc_s};
            for (int i = AVG_DEPTH-1; i > 0; i--) begin
                hist_d[i] = hist_q[i-1];
            end
            hist_d[0] = raw_inc_s;
            if (fill_q == 3'(AVG_DEPTH)) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + 3'd1;
            end
            report_valid_s  = (fill_q >= 3'(AVG_DEPTH-1));
            report_period_s = CNT_W'(sum_d >> AVG_SHIFT);
        end else begin
            fill_d = fill_q;
        end
    end

    // averaging history registers
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < AVG_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            sum_q  <= '0;
            fill_q <= 3'd0;
        end else begin
            hist_q <= hist_d;
            sum_q  <= sum_d;
            fill_q <= fill_d;
        end
    end
`else
    assign report_valid_s  = 1'b1;
    assign report_period_s = raw_inc_s;
`endif

    // FSM, cycle counter and output register next-state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        stalled_d = stalled_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise_s) begin
                    state_d = ST_MEASURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                // an edge coinciding with the timeout is a valid period, not a stall
                if (rise_s) begin
                    cnt_d = '0;
                    if (report_valid_s) begin
                        period_d = report_period_s;
                        valid_d  = 1'b1;
                    end else begin
                        period_d = period_q;
                        valid_d  = 1'b0;
                    end
                end else if (cnt_q == MAX_CNT) begin
                    state_d   = ST_STALLED;
                    stalled_d = 1'b1;
                end else begin
                    cnt_d = raw_inc_s;
                end
            end
            ST_STALLED: begin
                if (rise_s) begin
                    state_d   = ST_MEASURE;
                    stalled_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    state_d = ST_STALLED;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                stalled_d = 1'b0;
            end
        endcase
    end

    // FSM, counter and output registers
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
        end
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign stalled      = stalled_q;

endmodule

// File: tb/tb_sig_period_meter.sv
// Directed self-checking bench for sig_period_meter (default and
// SIG_PERIOD_METER_AVG_EN builds).
module tb_sig_period_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_a = 1'b0;
    logic        sig_b = 1'b0;
    logic [15:0] per_a, per_b;
    logic        val_a, val_b, stl_a, stl_b;

    int total = 0;
    int bad = 0;
    int strobes_a = 0;
    int strobes_b = 0;
    int stall_cyc_b = 0;

    always #5 clk = ~clk;

    sig_period_meter #(.CNT_W(16), .MAX_COUNT(65534)) dut_a (
        .clk_in(clk), .reset(rst_n), .sig_in(sig_a),
        .period_out(per_a), .period_valid(val_a), .stalled(stl_a)
    );

    sig_period_meter #(.CNT_W(16), .MAX_COUNT(100)) dut_b (
        .clk_in(clk), .reset(rst_n), .sig_in(sig_b),
        .period_out(per_b), .period_valid(val_b), .stalled(stl_b)
    );

    always @(negedge clk) begin
        if (val_a) strobes_a <= strobes_a + 1;
        if (val_b) strobes_b <= strobes_b + 1;
        if (stl_b) stall_cyc_b <= stall_cyc_b + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sig_a = 1'b0;
        sig_b = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        int seen;
        int s;
        seen = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((i % 3) == 0) begin
                sig_a = ~sig_a;
                sig_b = ~sig_b;
            end
            tick(1);
            if (per_a !== 16'd0 || val_a !== 1'b0 || stl_a !== 1'b0 ||
                per_b !== 16'd0 || val_b !== 1'b0 || stl_b !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_hold: nonzero_cycles=%0d expected=0", seen);
        end
        sig_a = 1'b0;
        sig_b = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        total++;
        if (per_a !== 16'd0 || val_a !== 1'b0 || stl_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: per=%0d val=%0b stl=%0b expected 0/0/0", per_a, val_a, stl_a);
        end
`ifndef SIG_PERIOD_METER_AVG_EN
        s = strobes_a;
        sig_a = 1'b1; tick(20); sig_a = 1'b0; tick(80);
        total++;
        if (strobes_a !== s) begin
            bad++;
            $display("FAIL reset_first_edge: strobes=%0d expected=%0d", strobes_a - s, 0);
        end
        sig_a = 1'b1;
        tick(3);
        total++;
        if (val_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_early_strobe: val=%0b expected=0", val_a);
        end
        tick(1);
        total++;
        if (val_a !== 1'b1 || per_a !== 16'd100) begin
            bad++;
            $display("FAIL reset_second_edge: val=%0b per=%0d expected 1/100", val_a, per_a);
        end
`else
        s = 0;
`endif
    endtask

    task automatic test_steady();
        int s;
        do_reset();
        s = strobes_a;
        sig_a = 1'b1; tick(1176); sig_a = 1'b0; tick(1176);
        sig_a = 1'b1;
        tick(3);
        total++;
        if (val_a !== 1'b0) begin
            bad++;
            $display("FAIL steady_latency3: val=%0b expected=0", val_a);
        end
        tick(1);
        total++;
        if (val_a !== 1'b1 || per_a !== 16'd2352) begin
            bad++;
            $display("FAIL steady_first: val=%0b per=%0d expected 1/2352", val_a, per_a);
        end
        tick(1);
        total++;
        if (val_a !== 1'b0 || per_a !== 16'd2352) begin
            bad++;
            $display("FAIL steady_one_cycle: val=%0b per=%0d expected 0/2352", val_a, per_a);
        end
        tick(1171); sig_a = 1'b0; tick(1176);
        sig_a = 1'b1;
        tick(4);
        total++;
        if (val_a !== 1'b1 || per_a !== 16'd2352 || strobes_a - s !== 1) begin
            bad++;
            $display("FAIL steady_second: val=%0b per=%0d prior_strobes=%0d expected 1/2352/1", val_a, per_a, strobes_a - s);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        do_reset();
        sig_a = 1'b1; tick(1176); sig_a = 1'b0; tick(1176);
        sig_a = 1'b1; tick(500);
        rst_n = 1'b0;
        #1;
        total++;
        if (per_a !== 16'd0 || val_a !== 1'b0 || stl_a !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_clear: per=%0d val=%0b stl=%0b expected 0/0/0", per_a, val_a, stl_a);
        end
        sig_a = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        s = strobes_a;
        sig_a = 1'b1; tick(1176); sig_a = 1'b0; tick(1176);
        total++;
        if (strobes_a !== s) begin
            bad++;
            $display("FAIL mid_reset_first_edge: strobes=%0d expected=0", strobes_a - s);
        end
        sig_a = 1'b1;
        tick(4);
        total++;
        if (val_a !== 1'b1 || per_a !== 16'd2352) begin
            bad++;
            $display("FAIL mid_reset_second_edge: val=%0b per=%0d expected 1/2352", val_a, per_a);
        end
    endtask

    task automatic test_stall();
        int s;
        do_reset();
        s = strobes_b;
        sig_b = 1'b1; tick(20); sig_b = 1'b0; tick(84);
        total++;
        if (stl_b !== 1'b0) begin
            bad++;
            $display("FAIL stall_early: stalled=%0b expected=0", stl_b);
        end
        tick(1);
        total++;
        if (stl_b !== 1'b1) begin
            bad++;
            $display("FAIL stall_assert: stalled=%0b expected=1", stl_b);
        end
        tick(40);
        sig_b = 1'b1;
        tick(3);
        total++;
        if (stl_b !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold: stalled=%0b expected=1", stl_b);
        end
        tick(1);
        total++;
        if (stl_b !== 1'b0 || strobes_b !== s) begin
            bad++;
            $display("FAIL stall_clear: stalled=%0b strobes=%0d expected 0/0", stl_b, strobes_b - s);
        end
        tick(16); sig_b = 1'b0; tick(30);
        sig_b = 1'b1;
        tick(4);
        total++;
        if (val_b !== 1'b1 || per_b !== 16'd50 || strobes_b - s !== 0) begin
            bad++;
            $display("FAIL stall_recover: val=%0b per=%0d prior_strobes=%0d expected 1/50/0", val_b, per_b, strobes_b - s);
        end
    endtask

    task automatic test_simultaneous();
        int sc;
        sc = stall_cyc_b;
        tick(16); sig_b = 1'b0; tick(81);
        sig_b = 1'b1;
        tick(4);
        total++;
        if (val_b !== 1'b1 || per_b !== 16'd101) begin
            bad++;
            $display("FAIL simul_first: val=%0b per=%0d expected 1/101", val_b, per_b);
        end
        tick(16); sig_b = 1'b0; tick(81);
        sig_b = 1'b1;
        tick(4);
        total++;
        if (val_b !== 1'b1 || per_b !== 16'd101) begin
            bad++;
            $display("FAIL simul_second: val=%0b per=%0d expected 1/101", val_b, per_b);
        end
        total++;
        if (stall_cyc_b !== sc) begin
            bad++;
            $display("FAIL simul_no_stall: stalled_cycles=%0d expected=0", stall_cyc_b - sc);
        end
    endtask

    task automatic test_avg();
        int s;
        do_reset();
        s = strobes_a;
        sig_a = 1'b1; tick(10); sig_a = 1'b0; tick(90);
        sig_a = 1'b1; tick(10); sig_a = 1'b0; tick(190);
        sig_a = 1'b1; tick(10); sig_a = 1'b0; tick(290);
        sig_a = 1'b1; tick(10); sig_a = 1'b0; tick(390);
        total++;
        if (strobes_a !== s) begin
            bad++;
            $display("FAIL avg_suppressed: strobes=%0d expected=0", strobes_a - s);
        end
        sig_a = 1'b1;
        tick(3);
        total++;
        if (val_a !== 1'b0) begin
            bad++;
            $display("FAIL avg_latency3: val=%0b expected=0", val_a);
        end
        tick(1);
        total++;
        if (val_a !== 1'b1 || per_a !== 16'd250) begin
            bad++;
            $display("FAIL avg_first: val=%0b per=%0d expected 1/250", val_a, per_a);
        end
        tick(6); sig_a = 1'b0; tick(91);
        sig_a = 1'b1;
        tick(4);
        total++;
        if (val_a !== 1'b1 || per_a !== 16'd250 || strobes_a - s !== 1) begin
            bad++;
            $display("FAIL avg_next: val=%0b per=%0d prior_strobes=%0d expected 1/250/1", val_a, per_a, strobes_a - s);
        end
    endtask

    initial begin
        test_reset();
`ifdef SIG_PERIOD_METER_AVG_EN
        test_avg();
`else
        test_steady();
        test_reset_mid();
`endif
        test_stall();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
